// File: rtl/vga_sync_rx.sv
// Receive-side VGA timing recovery: rebuilds pixel_x/pixel_y/video_on from an
// active-low hsync/vsync pair and checks every sync edge against the nominal frame.
module vga_sync_rx #(
    parameter int unsigned HD         = 640,
    parameter int unsigned HB         = 16,
    parameter int unsigned HR         = 96,
    parameter int unsigned HF         = 48,
    parameter int unsigned VD         = 480,
    parameter int unsigned VB         = 33,
    parameter int unsigned VR         = 2,
    parameter int unsigned VF         = 10,
    parameter int unsigned LOCK_LINES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       p_tick,
    input  logic       hsync,
    input  logic       vsync,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       video_on,
    output logic       locked,
    output logic       frame_start,
    output logic       sync_err
);
    localparam int unsigned H_TOTAL = HD + HB + HR + HF;
    localparam int unsigned HS      = HD + HB;
    localparam int unsigned HE      = HS + HR;
    localparam int unsigned V_TOTAL = VD + VB + VR + VF;
    localparam int unsigned VS      = VD + VB;
    localparam int unsigned VE      = VS + VR;
    localparam int unsigned GW      = $clog2(LOCK_LINES + 1);

    localparam logic [9:0]    HD_L     = 10'(HD);
    localparam logic [9:0]    VD_L     = 10'(VD);
    localparam logic [9:0]    H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]    V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0]    HS_L     = 10'(HS);
    localparam logic [9:0]    HS_M1    = 10'(HS - 1);
    localparam logic [9:0]    HE_M1    = 10'(HE - 1);
    localparam logic [9:0]    VS_L     = 10'(VS);
    localparam logic [9:0]    VS_M1    = 10'(VS - 1);
    localparam logic [9:0]    VE_M1    = 10'(VE - 1);
    localparam logic [GW-1:0] GOOD_MAX = GW'(LOCK_LINES);

    typedef enum logic [1:0] {SEARCH, HLOCK, LOCKED} state_t;

    state_t        state_q, state_d;
    logic [9:0]    h_q, h_d, v_q, v_d;
    logic          hs_prev_q, hs_prev_d, vs_prev_q, vs_prev_d;
    logic [GW-1:0] good_q, good_d;
    logic          aligned_q, aligned_d;
    logic          locked_q, locked_d;
    logic          frame_start_q, frame_start_d;
    logic          sync_err_q, sync_err_d;

    logic hfall, hrise, vfall, vrise, h_wrap, err;

    always_comb begin
        hfall  = p_tick & hs_prev_q & ~hsync;
        hrise  = p_tick & ~hs_prev_q & hsync;
        vfall  = p_tick & vs_prev_q & ~vsync;
        vrise  = p_tick & ~vs_prev_q & vsync;
        h_wrap = (h_q == H_LAST);
        err    = 1'b0;

        state_d       = state_q;
        h_d           = h_q;
        v_d           = v_q;
        hs_prev_d     = hs_prev_q;
        vs_prev_d     = vs_prev_q;
        good_d        = good_q;
        aligned_d     = aligned_q;
        locked_d      = locked_q;
        frame_start_d = 1'b0;
        sync_err_d    = 1'b0;

        if (p_tick) begin
            hs_prev_d = hsync;
            vs_prev_d = vsync;
            h_d       = h_wrap ? '0 : h_q + 10'd1;
            v_d       = h_wrap ? ((v_q == V_LAST) ? '0 : v_q + 10'd1) : v_q;

            if (state_q == SEARCH) begin
                if (hfall) begin
                    h_d       = HS_L;
                    good_d    = '0;
                    aligned_d = 1'b0;
                    state_d   = HLOCK;
                end
            end else begin
                // Each check fires both on an edge in the wrong place and on a missing edge.
                if (hfall != (h_q == HS_M1)) err = 1'b1;
                if (hrise != (h_q == HE_M1)) err = 1'b1;
                if (vfall && !h_wrap)        err = 1'b1;
                if (aligned_q) begin
                    if (h_wrap && (vfall != (v_q == VS_M1)))  err = 1'b1;
                    if (vrise != (h_wrap && (v_q == VE_M1)))  err = 1'b1;
                end

                if (err) begin
                    // Counters keep free-running; the offending edge is not reused as a load.
                    state_d    = SEARCH;
                    locked_d   = 1'b0;
                    sync_err_d = 1'b1;
                    good_d     = '0;
                    aligned_d  = 1'b0;
                end else begin
                    if (vfall) begin
                        v_d       = VS_L;
                        aligned_d = 1'b1;
                    end
                    if (hfall && (state_q == HLOCK) && (good_q != GOOD_MAX))
                        good_d = good_q + GW'(1);
                    if ((state_q == HLOCK) && (good_d == GOOD_MAX) && aligned_d) begin
                        state_d  = LOCKED;
                        locked_d = 1'b1;
                    end
                    frame_start_d = locked_d && (h_d == '0) && (v_d == '0);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= SEARCH;
            h_q           <= '0;
            v_q           <= '0;
            hs_prev_q     <= 1'b1;
            vs_prev_q     <= 1'b1;
            good_q        <= '0;
            aligned_q     <= 1'b0;
            locked_q      <= 1'b0;
            frame_start_q <= 1'b0;
            sync_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            h_q           <= h_d;
            v_q           <= v_d;
            hs_prev_q     <= hs_prev_d;
            vs_prev_q     <= vs_prev_d;
            good_q        <= good_d;
            aligned_q     <= aligned_d;
            locked_q      <= locked_d;
            frame_start_q <= frame_start_d;
            sync_err_q    <= sync_err_d;
        end
    end

    assign pixel_x     = h_q;
    assign pixel_y     = v_q;
    assign locked      = locked_q;
    assign frame_start = frame_start_q;
    assign sync_err    = sync_err_q;
    assign video_on    = locked_q && (h_q < HD_L) && (v_q < VD_L);

endmodule

// File: tb/tb_vga_sync_rx.sv
// Bench for vga_sync_rx on a shrunken 30x15 frame: a source-coordinate model of the
// sync rules is compared every cycle, and lock/error/frame ticks are pinned by hand.
module tb_vga_sync_rx;
    localparam int HD = 16, HB = 4, HR = 6, HF = 4;
    localparam int VD = 8,  VB = 3, VR = 2, VF = 2;
    localparam int LOCK_LINES = 4;
    localparam int HT = HD + HB + HR + HF;   // 30
    localparam int HS = HD + HB;             // 20
    localparam int HE = HS + HR;             // 26
    localparam int VT = VD + VB + VR + VF;   // 15
    localparam int VS = VD + VB;             // 11
    localparam int VE = VS + VR;             // 13
    localparam int FRAME = HT * VT;          // 450 pixel ticks
    localparam int N_TICKS = 10 * FRAME;

    // Injected faults (global line / frame indices)
    localparam int F_EARLY_LINE = 47;        // frame 3 line 2: hsync falls at HS-1
    localparam int F_SHORT_LINE = 65;        // frame 4 line 5: hsync low width HR-1
    localparam int F_NOV_FRAME  = 5;         // vsync suppressed for the whole frame
    localparam int RST_TICK     = 117 * HT + 5;   // frame 7 line 12 sx 5
    localparam int HOLD_TICK    = 8 * FRAME + 13 * HT + 10;

    logic       clk, reset, p_tick, hsync, vsync;
    logic [9:0] pixel_x, pixel_y;
    logic       video_on, locked, frame_start, sync_err;

    vga_sync_rx #(
        .HD(HD), .HB(HB), .HR(HR), .HF(HF),
        .VD(VD), .VB(VB), .VR(VR), .VF(VF),
        .LOCK_LINES(LOCK_LINES)
    ) dut (
        .clk(clk), .reset(reset), .p_tick(p_tick), .hsync(hsync), .vsync(vsync),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .video_on(video_on),
        .locked(locked), .frame_start(frame_start), .sync_err(sync_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0, failed = 0;
    int cur_tick = -1, cur_sx = 0, cur_sy = 0;
    bit run = 0;

    // Model state, in source coordinates
    bit m_tracking, m_vseen, m_locked, m_err, m_fs;
    bit m_hs_prev, m_vs_prev, m_hok, m_vok, m_xk, m_yk;
    int m_lines, m_x, m_y;

    int lock_q[$], err_q[$], fs_q[$];
    bit prev_locked = 0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s tick=%0d got=%0d want=%0d", name, cur_tick, act, exp);
        end
    endtask

    task automatic model_reset();
        m_tracking = 0; m_vseen = 0; m_locked = 0; m_err = 0; m_fs = 0;
        m_hs_prev = 1; m_vs_prev = 1; m_hok = 0; m_vok = 0; m_lines = 0;
        m_x = 0; m_y = 0; m_xk = 1; m_yk = 1;
    endtask

    task automatic model_tick(input int sx, input int sy, input bit hs, input bit vs);
        bit hf, hr, vf, vr, bad;
        hf = m_hs_prev & ~hs;
        hr = ~m_hs_prev & hs;
        vf = m_vs_prev & ~vs;
        vr = ~m_vs_prev & vs;
        m_err = 0;
        m_fs  = 0;
        if (!m_tracking) begin
            if (hf) begin
                m_tracking = 1; m_lines = 0; m_vseen = 0;
                m_hok = (sx == HS);
            end
        end else begin
            // Edges must appear exactly at their nominal source positions
            bad = (hf != (sx == HS)) || (hr != (sx == HE)) || (vf && sx != 0);
            if (m_vseen)
                bad = bad || (sx == 0 && (vf != (sy == VS))) || (vr != (sx == 0 && sy == VE));
            if (bad) begin
                m_tracking = 0; m_locked = 0; m_err = 1;
            end else begin
                if (vf) begin m_vseen = 1; m_vok = (sy == VS); end
                if (hf && m_lines < LOCK_LINES) m_lines++;
                if (m_lines == LOCK_LINES && m_vseen) m_locked = 1;
                m_fs = m_locked && sx == 0 && sy == 0;
            end
        end
        m_hs_prev = hs;
        m_vs_prev = vs;
        if (m_hok) m_x = sx;
        m_xk = m_hok;
        if (m_vok) m_y = sy;
        m_yk = m_vok;
    endtask

    task automatic set_src(input int g);
        int gl;
        cur_sx = g % HT;
        gl     = g / HT;
        cur_sy = gl % VT;
        hsync  = !(cur_sx >= HS && cur_sx < HE);
        if (gl == F_EARLY_LINE && cur_sx == HS - 1) hsync = 1'b0;
        if (gl == F_SHORT_LINE && cur_sx == HE - 1) hsync = 1'b1;
        vsync  = !(cur_sy >= VS && cur_sy < VE);
        if (gl / VT == F_NOV_FRAME) vsync = 1'b1;
    endtask

    task automatic clk_step(input bit tick, input bit rst_n);
        p_tick = tick;
        reset  = rst_n;
        @(posedge clk);
        if (!rst_n) model_reset();
        else if (tick) model_tick(cur_sx, cur_sy, hsync, vsync);
        else begin m_err = 0; m_fs = 0; end
        #1;
    endtask

    always @(negedge clk) begin
        if (run) begin
            chk("locked", int'(locked), int'(m_locked));
            chk("sync_err", int'(sync_err), int'(m_err));
            chk("frame_start", int'(frame_start), int'(m_fs));
            chk("video_on", int'(video_on), int'(m_locked && m_x < HD && m_y < VD));
            if (m_xk) chk("pixel_x", int'(pixel_x), m_x);
            if (m_yk) chk("pixel_y", int'(pixel_y), m_y);
            if (locked && !prev_locked) lock_q.push_back(cur_tick);
            if (sync_err) err_q.push_back(cur_tick);
            if (frame_start) fs_q.push_back(cur_tick);
            prev_locked = locked;
        end
    end

    int exp_lock[5] = '{330, 1680, 2130, 3030, 3930};
    int exp_err[3]  = '{1429, 1975, 2580};
    int exp_fs[7]   = '{450, 900, 1350, 1800, 2250, 3150, 4050};

    initial begin
        reset = 1'b0; p_tick = 1'b0; hsync = 1'b1; vsync = 1'b1;
        model_reset();
        run = 1;
        repeat (3) clk_step(0, 0);
        for (int g = 0; g < N_TICKS; g++) begin
            if (g == RST_TICK) begin
                clk_step(0, 0);
                chk("rst_pixel_x", int'(pixel_x), 0);
                chk("rst_pixel_y", int'(pixel_y), 0);
                chk("rst_locked", int'(locked), 0);
            end
            if (g == HOLD_TICK) begin
                repeat (50) clk_step(0, 1);
                chk("hold_pixel_x", int'(pixel_x), 9);
                chk("hold_pixel_y", int'(pixel_y), 13);
                chk("hold_locked", int'(locked), 1);
            end
            set_src(g);
            cur_tick = g;
            clk_step(1, 1);
            clk_step(0, 1);
        end
        run = 0;

        chk("lock_count", lock_q.size(), 5);
        for (int i = 0; i < 5; i++)
            chk("lock_tick", (i < lock_q.size()) ? lock_q[i] : -1, exp_lock[i]);
        chk("err_count", err_q.size(), 3);
        for (int i = 0; i < 3; i++)
            chk("err_tick", (i < err_q.size()) ? err_q[i] : -1, exp_err[i]);
        chk("fs_count", fs_q.size(), 7);
        for (int i = 0; i < 7; i++)
            chk("fs_tick", (i < fs_q.size()) ? fs_q[i] : -1, exp_fs[i]);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/vga_sync_rx.md
# vga_sync_rx

Receive-side VGA timing recovery for the 640x480 display path. Consumes an active-low hsync/vsync pair plus the 25 MHz pixel enable and rebuilds pixel_x/pixel_y/video_on for downstream capture and checking logic (frame grabber, bench monitors). Checks every sync edge against the nominal 800x525 frame and reports lock and violations.

## Interface
- HD, 640, horizontal display pixels
- HB, 16, pixels between end of display and hsync assertion
- HR, 96, hsync low width in pixels
- HF, 48, pixels between hsync deassertion and line end
- VD, 480, display lines
- VB, 33, lines between end of display and vsync assertion
- VR, 2, vsync low width in lines
- VF, 10, lines between vsync deassertion and frame end
- LOCK_LINES, 4, consecutive correct hsync falls required before lock
- clk  input  1  system clock, 100 MHz
- reset  input  1  synchronous, active-low (0 = reset)
- p_tick  input  1  pixel enable; all sampling and counting occur only on clk edges where p_tick=1
- hsync  input  1  active-low horizontal sync
- vsync  input  1  active-low vertical sync
- pixel_x  output  10  recovered column, 0..799
- pixel_y  output  10  recovered row, 0..524
- video_on  output  1  locked && pixel_x<HD && pixel_y<VD
- locked  output  1  timing recovered and verified
- frame_start  output  1  one-clk pulse when locked and counters move to (0,0)
- sync_err  output  1  one-clk pulse on any timing violation

## Operation
- Derived: H_TOTAL=HD+HB+HR+HF (800), HS=HD+HB (656), HE=HS+HR (752), V_TOTAL=VD+VB+VR+VF (525), VS=VD+VB (513), VE=VS+VR (515).
- hsync/vsync sampled into hs_prev/vs_prev on p_tick. hfall = p_tick & hs_prev & ~hsync; hrise, vfall likewise.
- h counter: increments on p_tick, wraps H_TOTAL-1 -> 0. v counter: increments on h wrap, wraps V_TOTAL-1 -> 0.
- States: SEARCH, HLOCK, LOCKED.
- SEARCH: counters free; on hfall load h=HS, clear good_lines, clear v_aligned, go HLOCK. No errors reported.
- HLOCK/LOCKED checks, evaluated on each p_tick:
  - hfall with h != HS-1 -> error; h == HS-1 with no hfall -> error (missing hsync).
  - hrise with h != HE-1, or h == HE-1 with no hrise -> error.
  - vfall: must coincide with h == H_TOTAL-1; on it v loads VS (not v+1), v_aligned set. vfall at any other h -> error.
  - once v_aligned: vfall at h == H_TOTAL-1 with v != VS-1 -> error; v == VS-1 at h wrap with no vfall -> error; vsync rise must coincide with line wrap into VE, else error.
- HLOCK: each correct hfall increments good_lines (saturate at LOCK_LINES). Go LOCKED when good_lines == LOCK_LINES and v_aligned.
- Any error: sync_err pulse, state -> SEARCH, locked=0. Error outranks a simultaneous lock transition. The hfall that caused the error is not reused as a SEARCH load; relock starts at the next hfall.

## Timing
- Reset (reset=0 at clk edge): state SEARCH; pixel_x=0, pixel_y=0, video_on=0, locked=0, frame_start=0, sync_err=0, hs_prev=vs_prev=1, good_lines=0, v_aligned=0.
- All outputs registered. Counters change only on p_tick clk edges; with p_tick=0 everything holds, including sync_err/frame_start (pulses stay 0).
- pixel_x = HS on the clk edge after the p_tick sampling the first hfall in SEARCH.
- locked rises on the same edge that registers the qualifying event; sync_err and locked fall on the edge that registers the error.
- frame_start asserts on the edge where pixel_x,pixel_y become 0,0 while locked (and not dropping lock that edge).
- video_on is combinational from registered pixel_x, pixel_y, locked; 0 whenever unlocked.

## Test plan
- Clean 800x525 stream, p_tick every 2nd clk, sync edges at h=HS/HE and vsync on lines VS..VE-1 -> locked after 4 good lines and first vsync fall; pixel_x/y match source counts exactly; frame_start once per 420000 p_ticks; sync_err never.
- Locked stream, one hsync fall arriving 1 pixel early -> sync_err one clk, locked=0 next edge; relock after 4 further lines plus next vsync fall.
- Locked stream, hsync low width 95 -> sync_err at the early rise, state SEARCH.
- Locked stream, vsync suppressed for one frame -> sync_err at wrap of line 512; pixel outputs keep counting; video_on=0.
- reset=0 for one clk mid-frame while locked -> all outputs 0 next edge; relock on a later frame.
- Hold p_tick=0 for 50 clks while locked -> pixel_x, pixel_y, locked unchanged; no pulses.
